// File: rtl/clk_meter_pkg.sv
// Shared definitions for the clock ratio meter.
//   meter_state_t   : measurement FSM states
//   DEF_CNT_W       : default period/high counter width
//   DEF_LOCK_COUNT  : default number of consecutive equal measurements for lock
//   MATCH_W         : width of the lock match counter (holds 0..15)
//   is_pow2()       : true when the argument is a power of two and at least 2
package clk_meter_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meter_state_t;

  localparam int DEF_CNT_W      = 8;
  localparam int DEF_LOCK_COUNT = 4;
  localparam int MATCH_W        = 4;

  // A period of 1 cannot come from a real divider, so 1 is not reported as pow2.
  function automatic logic is_pow2(input logic [31:0] x);
    is_pow2 = (x >= 32'd2) && ((x & (x - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/sig_edge_detect.sv
// Edge detector for a signal already synchronous to clk.
//   clk  in  : clock
//   rst  in  : synchronous active-high reset
//   sig  in  : monitored level
//   rise out : sig is high this cycle and was low last cycle
//   fall out : sig is low this cycle and was high last cycle
// The history register resets to 1 so a level that is already high when
// reset is released is not mistaken for a rising edge.
module sig_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_d;

  // One-cycle history of the monitored level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_d <= 1'b1;
    end else begin
      sig_d <= sig;
    end
  end

  assign rise = sig & ~sig_d;
  assign fall = ~sig & sig_d;

endmodule

// File: rtl/clk_ratio_meter.sv
// Measures a slow signal in clk_in cycles: period (rise to rise), high time,
// duty symmetry, power-of-two ratio, lock to a stable period, and loss of signal.
//   clk_in     in  : system clock
//   rst        in  : synchronous active-high reset
//   sig_in     in  : signal under test, synchronous to clk_in
//   period     out : last measured period in cycles
//   high_time  out : high cycles within that period
//   meas_valid out : one-cycle pulse, period/high_time updated
//   symmetric  out : 2*high_time == period
//   pow2       out : period is a power of two, >= 2
//   locked     out : LOCK_COUNT consecutive measurements equalled their predecessor
//   timeout    out : one-cycle pulse, no rising edge within 2**CNT_W-1 cycles
// All outputs are registered and change one cycle after the rising-edge cycle.
module clk_ratio_meter
  import clk_meter_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             symmetric,
  output logic             pow2,
  output logic             locked,
  output logic             timeout
);

  localparam logic [CNT_W-1:0]   MAX_CNT   = {CNT_W{1'b1}};
  localparam logic [MATCH_W-1:0] MATCH_MAX = {MATCH_W{1'b1}};
  localparam logic [MATCH_W-1:0] LOCK_TGT  = MATCH_W'(LOCK_COUNT);

  meter_state_t       state;
  logic [CNT_W-1:0]   per_cnt;
  logic [CNT_W-1:0]   hi_cnt;
  logic [CNT_W-1:0]   ref_period;
  logic               has_ref;
  logic [MATCH_W-1:0] match_cnt;

  logic               rise;
  logic               fall_unused;
  logic [MATCH_W-1:0] match_inc;
  logic               period_match;
  logic               sym_new;
  logic               pow2_new;

  sig_edge_detect u_edge (
    .clk  (clk_in),
    .rst  (rst),
    .sig  (sig_in),
    .rise (rise),
    .fall (fall_unused)
  );

  // Values derived from the counts being captured on a rising edge.
  always_comb begin
    period_match = (per_cnt == ref_period);
    if (match_cnt == MATCH_MAX) begin
      match_inc = match_cnt;
    end else begin
      match_inc = match_cnt + MATCH_W'(1);
    end
    sym_new  = ({hi_cnt, 1'b0} == {1'b0, per_cnt});
    pow2_new = is_pow2(32'(per_cnt));
  end

  // Measurement FSM, counters, lock tracking and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state      <= IDLE;
      per_cnt    <= '0;
      hi_cnt     <= '0;
      ref_period <= '0;
      has_ref    <= 1'b0;
      match_cnt  <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      symmetric  <= 1'b0;
      pow2       <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      case (state)
        IDLE: begin
          // The rise cycle itself is the first period cycle and is high.
          if (rise) begin
            state   <= MEASURE;
            per_cnt <= CNT_W'(1);
            hi_cnt  <= CNT_W'(1);
          end else begin
            state <= IDLE;
          end
        end
        MEASURE: begin
          if (rise) begin
            // A rise at per_cnt == MAX is still a valid measurement.
            period     <= per_cnt;
            high_time  <= hi_cnt;
            symmetric  <= sym_new;
            pow2       <= pow2_new;
            meas_valid <= 1'b1;
            per_cnt    <= CNT_W'(1);
            hi_cnt     <= CNT_W'(1);
            ref_period <= per_cnt;
            if (!has_ref) begin
              // First measurement after IDLE only seeds the reference.
              has_ref   <= 1'b1;
              match_cnt <= '0;
              locked    <= 1'b0;
            end else if (period_match) begin
              match_cnt <= match_inc;
              locked    <= (match_inc >= LOCK_TGT);
            end else begin
              match_cnt <= '0;
              locked    <= 1'b0;
            end
          end else if (per_cnt == MAX_CNT) begin
            // Counter would saturate: signal is lost, drop back to IDLE.
            state      <= IDLE;
            timeout    <= 1'b1;
            per_cnt    <= '0;
            hi_cnt     <= '0;
            ref_period <= '0;
            has_ref    <= 1'b0;
            match_cnt  <= '0;
            period     <= '0;
            high_time  <= '0;
            symmetric  <= 1'b0;
            pow2       <= 1'b0;
            locked     <= 1'b0;
          end else begin
            // hi_cnt only advances with per_cnt, so it never exceeds it.
            per_cnt <= per_cnt + CNT_W'(1);
            hi_cnt  <= hi_cnt + {{(CNT_W-1){1'b0}}, sig_in};
          end
        end
        default: begin
          state   <= IDLE;
          per_cnt <= '0;
          hi_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Self-checking bench for clk_ratio_meter: table of regular patterns, hand
// sequences for lock switching, timeout and mid-period reset, then random
// stimulus, all checked cycle by cycle against a rise-time based model.
module tb_clk_ratio_meter;

  localparam int CNT_W      = 8;
  localparam int LOCK_COUNT = 4;
  localparam int MAXP       = (1 << CNT_W) - 1;

  logic             clk_in = 1'b0;
  logic             rst    = 1'b1;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             symmetric;
  logic             pow2;
  logic             locked;
  logic             timeout;

  clk_ratio_meter #(.CNT_W(CNT_W), .LOCK_COUNT(LOCK_COUNT)) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .sig_in     (sig_in),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .symmetric  (symmetric),
    .pow2       (pow2),
    .locked     (locked),
    .timeout    (timeout)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [7:0] p;
    logic [7:0] h;
    logic       lk;
    logic       sym;
    logic       p2;
  } meas_t;

  typedef struct {
    int hi;
    int lo;
    int exp_per;
    int exp_high;
    bit exp_sym;
    bit exp_p2;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  int n        = 0;
  int last_rise_n = 0;
  int last_to_n   = 0;
  int to_count    = 0;
  logic prev_drv  = 1'b1;
  meas_t mq[$];

  // Reference model state: in terms of rise times and observed periods.
  bit   m_armed = 1'b0;
  logic m_prev  = 1'b1;
  int   m_last_rise = 0;
  int   m_ones = 0;
  int   hist[$];
  logic [7:0] e_per = 8'd0;
  logic [7:0] e_high = 8'd0;
  logic e_mv = 1'b0, e_sym = 1'b0, e_p2 = 1'b0, e_lk = 1'b0, e_to = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, n);
  endtask

  function automatic bit ref_pow2(input int p);
    for (int k = 1; k < 31; k++) if (p == (1 << k)) return 1'b1;
    return 1'b0;
  endfunction

  // Locked when the last LOCK_COUNT+1 periods since arming are all equal.
  function automatic bit ref_locked();
    int sz = hist.size();
    if (sz < LOCK_COUNT + 1) return 1'b0;
    for (int i = sz - LOCK_COUNT; i < sz; i++) if (hist[i] != hist[sz-1-LOCK_COUNT]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input logic s, input logic r);
    bit rise_m;
    int p;
    e_mv = 1'b0;
    e_to = 1'b0;
    if (r) begin
      m_armed = 1'b0; m_prev = 1'b1; hist.delete();
      e_per = 8'd0; e_high = 8'd0; e_sym = 1'b0; e_p2 = 1'b0; e_lk = 1'b0;
      return;
    end
    rise_m = s && !m_prev;
    m_prev = s;
    if (!m_armed) begin
      if (rise_m) begin
        m_armed = 1'b1; m_last_rise = n; m_ones = 1;
      end
    end else if (rise_m) begin
      p = n - m_last_rise;
      e_per = 8'(p); e_high = 8'(m_ones); e_mv = 1'b1;
      e_sym = (2 * m_ones == p); e_p2 = ref_pow2(p);
      hist.push_back(p);
      e_lk = ref_locked();
      m_last_rise = n; m_ones = 1;
    end else if (n - m_last_rise == MAXP) begin
      m_armed = 1'b0; hist.delete(); e_to = 1'b1;
      e_per = 8'd0; e_high = 8'd0; e_sym = 1'b0; e_p2 = 1'b0; e_lk = 1'b0;
    end else begin
      m_ones += int'(s);
    end
  endtask

  // One clock: drive at negedge, update model at posedge, sample 1 time unit later.
  task automatic cyc(input logic s, input logic r);
    @(negedge clk_in);
    sig_in = s;
    rst = r;
    @(posedge clk_in);
    n++;
    if (!r && s && !prev_drv) last_rise_n = n;
    prev_drv = r ? 1'b1 : s;
    model_step(s, r);
    #1;
    check("cycle", {period, high_time, meas_valid, symmetric, pow2, locked, timeout},
          {e_per, e_high, e_mv, e_sym, e_p2, e_lk, e_to});
    if (meas_valid === 1'b1) mq.push_back({period, high_time, locked, symmetric, pow2});
    if (timeout === 1'b1) begin
      to_count++;
      last_to_n = n;
    end
  endtask

  task automatic run_pattern(input int hi, input int lo, input int nper);
    for (int p = 0; p < nper; p++) begin
      for (int i = 0; i < hi; i++) cyc(1'b1, 1'b0);
      for (int i = 0; i < lo; i++) cyc(1'b0, 1'b0);
    end
  endtask

  task automatic restart();
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    mq.delete();
  endtask

  vec_t vecs[7];

  initial begin
    int fl;
    vecs[0] = '{1, 1, 2, 1, 1'b1, 1'b1};
    vecs[1] = '{8, 8, 16, 8, 1'b1, 1'b1};
    vecs[2] = '{3, 7, 10, 3, 1'b0, 1'b0};
    vecs[3] = '{4, 4, 8, 4, 1'b1, 1'b1};
    vecs[4] = '{5, 3, 8, 5, 1'b0, 1'b1};
    vecs[5] = '{100, 155, 255, 100, 1'b0, 1'b0};
    vecs[6] = '{2, 1, 3, 2, 1'b0, 1'b0};

    cyc(1'b0, 1'b1);
    check("reset_outputs", {period, high_time, meas_valid, symmetric, pow2, locked, timeout}, 64'd0);

    // Regular patterns: 7 rises give 6 measurements, lock on the 5th.
    for (int v = 0; v < 7; v++) begin
      restart();
      run_pattern(vecs[v].hi, vecs[v].lo, 7);
      check("tbl_meas_count", mq.size(), 6);
      if (mq.size() == 6) begin
        check("tbl_period", mq[5].p, vecs[v].exp_per);
        check("tbl_high", mq[5].h, vecs[v].exp_high);
        check("tbl_sym", mq[5].sym, vecs[v].exp_sym);
        check("tbl_pow2", mq[5].p2, vecs[v].exp_p2);
        fl = -1;
        for (int i = 0; i < 6; i++) if (mq[i].lk && fl < 0) fl = i;
        check("tbl_lock_index", fl, LOCK_COUNT);
      end
    end

    // Switch from div-16 to div-8 while locked.
    restart();
    run_pattern(8, 8, 7);
    check("d16_locked", locked, 1);
    mq.delete();
    run_pattern(4, 4, 6);
    check("switch_count", mq.size(), 6);
    if (mq.size() == 6) begin
      check("switch_last16", {mq[0].p, mq[0].lk}, {8'd16, 1'b1});
      check("switch_first8", {mq[1].p, mq[1].lk}, {8'd8, 1'b0});
      check("switch_4th_unlocked", mq[4].lk, 0);
      check("switch_relock", {mq[5].p, mq[5].lk}, {8'd8, 1'b1});
    end

    // Hold low after lock: timeout 255 cycles after the last rise.
    to_count = 0;
    for (int i = 0; i < 300; i++) cyc(1'b0, 1'b0);
    check("timeout_count", to_count, 1);
    check("timeout_gap", last_to_n - last_rise_n, MAXP);
    check("post_timeout_out", {period, high_time, symmetric, pow2, locked}, 64'd0);
    mq.delete();
    run_pattern(2, 2, 2);
    check("idle_first_rise", mq.size(), 1);
    if (mq.size() == 1) check("idle_second_period", mq[0].p, 4);

    // Stuck high also times out.
    to_count = 0;
    for (int i = 0; i < 300; i++) cyc(1'b1, 1'b0);
    check("stuck_high_timeout", to_count, 1);

    // Reset five cycles into a div-16 period.
    restart();
    run_pattern(8, 8, 3);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    mq.delete();
    check("mid_rst_outputs", {period, high_time, meas_valid, symmetric, pow2, locked, timeout}, 64'd0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0);
    run_pattern(8, 8, 2);
    check("after_rst_count", mq.size(), 1);
    if (mq.size() == 1) check("after_rst_period", mq[0].p, 16);

    // Random stimulus, checked every cycle by the model.
    for (int seg = 0; seg < 80; seg++) begin
      int kind = int'($urandom_range(0, 9));
      int h;
      case (kind)
        0: cyc(1'b0, 1'b1);
        1: for (int i = 0; i < int'($urandom_range(250, 300)); i++) cyc(1'b0, 1'b0);
        2: for (int i = 0; i < int'($urandom_range(250, 280)); i++) cyc(1'b1, 1'b0);
        3: begin
          h = int'($urandom_range(1, 127));
          run_pattern(h, MAXP - h + int'($urandom_range(0, 1)), 2);
        end
        4: run_pattern(int'($urandom_range(1, 8)), int'($urandom_range(1, 8)), 7);
        default: run_pattern(int'($urandom_range(1, 20)), int'($urandom_range(1, 20)),
                             int'($urandom_range(1, 8)));
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
